// File: rtl/sys_op_ctrl.sv
// sys_op_ctrl: system-op sequencer (ebreak / ecall / mret / wfi).
// Takes one system op from execute, stalls the pipeline while it drains,
// then halts, redirects (with an optional trap CSR write) or waits for an
// interrupt.
// Optional build macro: SYS_DRAIN_WDOG_EN adds a drain watchdog that halts
// the core when drain_done does not arrive within DRAIN_TIMEOUT cycles.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | pipeline running, waiting for a valid system op
// DRAIN    | op latched, pipeline stalled until drain_done
// REDIRECT | single cycle: flush + PC redirect (+ epc write for ecall)
// WFI      | stalled until irq_pending, then redirect to pc+4
// HALT     | ebreak or watchdog expiry, left only by reset
module sys_op_ctrl #(
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [63:0] ex_pc,
  input  logic        ebreak_op,
  input  logic        ecall_op,
  input  logic        mret_op,
  input  logic        wfi_op,
  input  logic        drain_done,
  input  logic        irq_pending,
  input  logic [63:0] mtvec,
  input  logic [63:0] mepc,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        epc_we,
  output logic [63:0] epc,
  output logic [3:0]  cause,
  output logic        halted,
  output logic        busy,
  output logic        timeout
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DRAIN    = 3'd1;
  localparam logic [2:0] S_REDIRECT = 3'd2;
  localparam logic [2:0] S_WFI      = 3'd3;
  localparam logic [2:0] S_HALT     = 3'd4;

  localparam logic [1:0] OP_EBREAK = 2'd0;
  localparam logic [1:0] OP_ECALL  = 2'd1;
  localparam logic [1:0] OP_MRET   = 2'd2;
  localparam logic [1:0] OP_WFI    = 2'd3;

  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

  logic [2:0]  state;
  logic [1:0]  op_q;
  logic [63:0] pc_q;
  logic [63:0] target_q;
  logic        op_start;
  logic [1:0]  op_sel;
  logic        wdog_expire;

  assign op_start = ex_valid && (ebreak_op || ecall_op || mret_op || wfi_op);

  // Fixed priority among simultaneously decoded ops
  always_comb begin
    op_sel = OP_WFI;
    if (ebreak_op)     op_sel = OP_EBREAK;
    else if (ecall_op) op_sel = OP_ECALL;
    else if (mret_op)  op_sel = OP_MRET;
  end

`ifdef SYS_DRAIN_WDOG_EN
  localparam logic [7:0] WDOG_LAST = 8'(DRAIN_TIMEOUT - 1);

  logic [7:0] drain_cnt;
  logic       timeout_q;

  // drain_done in the limit cycle wins over expiry
  assign wdog_expire = (state == S_DRAIN) && !drain_done && (drain_cnt == WDOG_LAST);

  // Drain cycle counter, cleared on DRAIN entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                drain_cnt <= 8'd0;
    else if (state == S_IDLE && op_start)   drain_cnt <= 8'd0;
    else if (state == S_DRAIN && !drain_done) drain_cnt <= drain_cnt + 8'd1;
  end

  // Sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              timeout_q <= 1'b0;
    else if (wdog_expire) timeout_q <= 1'b1;
  end

  assign timeout = timeout_q;
`else
  assign wdog_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  // Main sequencer: latches the op/pc and the redirect target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_EBREAK;
      pc_q     <= 64'h0;
      target_q <= 64'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_start) begin
            pc_q  <= ex_pc;
            op_q  <= op_sel;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            case (op_q)
              OP_EBREAK: state <= S_HALT;
              OP_ECALL: begin
                target_q <= mtvec;
                state    <= S_REDIRECT;
              end
              OP_MRET: begin
                target_q <= mepc;
                state    <= S_REDIRECT;
              end
              default: state <= S_WFI;
            endcase
          end else if (wdog_expire) begin
            state <= S_HALT;
          end
        end
        S_REDIRECT: state <= S_IDLE;
        S_WFI: begin
          if (irq_pending) begin
            target_q <= pc_q + 64'd4;
            state    <= S_REDIRECT;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state and latched registers only
  always_comb begin
    stall          = (state != S_IDLE);
    busy           = (state != S_IDLE);
    halted         = (state == S_HALT);
    redirect_valid = (state == S_REDIRECT);
    flush          = (state == S_REDIRECT);
    redirect_pc    = (state == S_REDIRECT) ? target_q : 64'h0;
    epc_we         = (state == S_REDIRECT) && (op_q == OP_ECALL);
    epc            = epc_we ? pc_q : 64'h0;
    cause          = epc_we ? CAUSE_ECALL_M : 4'h0;
  end

endmodule

// File: tb/tb_sys_op_ctrl.sv
// tb_sys_op_ctrl: directed self-checking bench for sys_op_ctrl.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_sys_op_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic        ebreak_op, ecall_op, mret_op, wfi_op;
  logic        drain_done, irq_pending;
  logic [63:0] mtvec, mepc;
  logic        stall, flush, redirect_valid, epc_we, halted, busy, timeout;
  logic [63:0] redirect_pc, epc;
  logic [3:0]  cause;

  int n_checks = 0;
  int n_errors = 0;

  sys_op_ctrl #(.DRAIN_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ebreak_op(ebreak_op), .ecall_op(ecall_op), .mret_op(mret_op), .wfi_op(wfi_op),
    .drain_done(drain_done), .irq_pending(irq_pending), .mtvec(mtvec), .mepc(mepc),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .epc_we(epc_we), .epc(epc), .cause(cause), .halted(halted), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_ops();
    ex_valid = 0; ebreak_op = 0; ecall_op = 0; mret_op = 0; wfi_op = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"},  stall, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_flush"},  flush, 0);
    chk({tag, "_rv"},     redirect_valid, 0);
    chk({tag, "_rpc"},    redirect_pc, 64'h0);
    chk({tag, "_epcwe"},  epc_we, 0);
    chk({tag, "_epc"},    epc, 64'h0);
    chk({tag, "_cause"},  cause, 0);
    chk({tag, "_tmo"},    timeout, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    tick(2);
    rst = 0;
  endtask

  initial begin
    rst = 1; clr_ops(); ex_pc = 0; drain_done = 0; irq_pending = 0;
    mtvec = 64'h1234; mepc = 64'h5678;
    tick(2);
    chk_all_zero("rst");
    rst = 0;
    tick();

    // ecall: 3 drain cycles without drain_done, then redirect to mtvec
    ex_valid = 1; ecall_op = 1; ex_pc = 64'h8000_0100;
    chk("ec_nostall_op", stall, 0);
    tick();
    clr_ops();
    for (int i = 0; i < 3; i++) begin
      chk("ec_drain_stall", stall, 1);
      chk("ec_drain_rv", redirect_valid, 0);
      tick();
    end
    chk("ec_drain_busy", busy, 1);
    drain_done = 1; mtvec = 64'h8000_0000;
    tick();
    drain_done = 0; mtvec = 64'h1234;
    chk("ec_rv", redirect_valid, 1);
    chk("ec_flush", flush, 1);
    chk("ec_rpc", redirect_pc, 64'h8000_0000);
    chk("ec_epcwe", epc_we, 1);
    chk("ec_epc", epc, 64'h8000_0100);
    chk("ec_cause", cause, 4'd11);
    tick();
    chk("ec_idle_rv", redirect_valid, 0);
    chk("ec_idle_stall", stall, 0);
    chk("ec_idle_epcwe", epc_we, 0);

    // op flags without ex_valid are ignored
    ecall_op = 1; wfi_op = 1;
    tick();
    clr_ops();
    chk("noval_stall", stall, 0);

    // mret: redirect to mepc sampled at drain_done, no epc write
    ex_valid = 1; mret_op = 1; ex_pc = 64'h100;
    tick();
    clr_ops();
    drain_done = 1; mepc = 64'h2000_0040;
    tick();
    drain_done = 0; mepc = 64'h5678;
    chk("mret_rv", redirect_valid, 1);
    chk("mret_rpc", redirect_pc, 64'h2000_0040);
    chk("mret_epcwe", epc_we, 0);
    chk("mret_cause", cause, 0);
    tick();

    // wfi at top of address space: pc+4 wraps to 0
    ex_valid = 1; wfi_op = 1; ex_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    clr_ops();
    irq_pending = 1;  // ignored while draining
    drain_done = 1;
    tick();
    drain_done = 0; irq_pending = 0;
    chk("wfi_enter_rv", redirect_valid, 0);
    tick(10);
    chk("wfi_wait_stall", stall, 1);
    chk("wfi_wait_rv", redirect_valid, 0);
    irq_pending = 1;
    tick();
    irq_pending = 0;
    chk("wfi_rv", redirect_valid, 1);
    chk("wfi_rpc", redirect_pc, 64'h0);
    chk("wfi_epcwe", epc_we, 0);
    tick();
    chk("wfi_idle", stall, 0);

    // wfi at ordinary pc
    ex_valid = 1; wfi_op = 1; ex_pc = 64'h1000;
    tick();
    clr_ops();
    drain_done = 1; tick(); drain_done = 0;
    irq_pending = 1; tick(); irq_pending = 0;
    chk("wfi2_rpc", redirect_pc, 64'h1004);
    tick();

    // drain with no drain_done: watchdog behaviour depends on build
`ifdef SYS_DRAIN_WDOG_EN
    ex_valid = 1; ecall_op = 1; ex_pc = 64'h40;
    tick();
    clr_ops();
    tick(3);
    drain_done = 1; mtvec = 64'h300;
    tick();
    drain_done = 0;
    chk("wd_done_wins_rv", redirect_valid, 1);
    chk("wd_done_wins_tmo", timeout, 0);
    tick();
    ex_valid = 1; wfi_op = 1;
    tick();
    clr_ops();
    tick(3);
    chk("wd_pre_halt", halted, 0);
    tick();
    chk("wd_halted", halted, 1);
    chk("wd_timeout", timeout, 1);
    tick(5);
    chk("wd_sticky", timeout, 1);
    do_reset();
    chk("wd_rst_tmo", timeout, 0);
`else
    ex_valid = 1; wfi_op = 1;
    tick();
    clr_ops();
    tick(20);
    chk("nowd_stall", stall, 1);
    chk("nowd_halted", halted, 0);
    chk("nowd_timeout", timeout, 0);
    do_reset();
    chk("nowd_rst_stall", stall, 0);
`endif
    tick();

    // ebreak with drain_done already high -> HALT for 100 cycles
    ex_valid = 1; ebreak_op = 1; drain_done = 1;
    tick();
    clr_ops();
    tick();
    drain_done = 0;
    for (int i = 0; i < 100; i++) begin
      irq_pending = i[0]; drain_done = i[1];
      ex_valid = 1; ecall_op = i[2];
      if (halted !== 1'b1 || stall !== 1'b1 || redirect_valid !== 1'b0) begin
        chk("halt_hold", {halted, stall, redirect_valid}, 3'b110);
        break;
      end
      tick();
    end
    clr_ops(); irq_pending = 0; drain_done = 0;
    chk("halt_halted", halted, 1);
    chk("halt_stall", stall, 1);
    #2 rst = 1;
    #1;
    chk_all_zero("halt_rst");
    tick();
    rst = 0;
    tick();

    // ebreak + ecall same cycle -> ebreak; second ecall during drain ignored
    ex_valid = 1; ebreak_op = 1; ecall_op = 1; ex_pc = 64'h77;
    tick();
    ebreak_op = 0;  // ecall still presented
    mtvec = 64'h900;
    tick();
    clr_ops();
    chk("pri_drain_stall", stall, 1);
    chk("pri_drain_rv", redirect_valid, 0);
    drain_done = 1;
    tick();
    drain_done = 0;
    chk("pri_halted", halted, 1);
    chk("pri_rv", redirect_valid, 0);
    do_reset();
    tick();

    // reset mid-drain of mret: async return to IDLE, no redirect
    ex_valid = 1; mret_op = 1; ex_pc = 64'h500; mepc = 64'hABC0;
    tick();
    clr_ops();
    tick();
    chk("mid_drain_stall", stall, 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rv", redirect_valid, 0);
    drain_done = 1;
    tick();
    rst = 0;
    tick();
    chk("mid_after_rv", redirect_valid, 0);
    chk("mid_after_stall", stall, 0);
    drain_done = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout_guard: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
